// File: rtl/brent_add_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the shared Brent adder.
package brent_pkg;

    localparam int BRENT_N    = 32;
    localparam int BRENT_NREQ = 4;
    localparam int BRENT_IDW  = $clog2(BRENT_NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int next_idx(input int idx, input int nreq);
        return (idx + 1) % nreq;
    endfunction

endpackage

// File: rtl/brent_add_arbiter_if.sv
// Requester and response bus of the adder arbiter; master = clients, slave = arbiter.
interface brent_add_arbiter_if
    import brent_pkg::*;
#(
    parameter int N    = BRENT_N,
    parameter int NREQ = BRENT_NREQ,
    parameter int IDW  = BRENT_IDW
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
    );

endinterface

// File: rtl/brent_add_arbiter_adder.sv
// Combinational Brent-Kung prefix adder: sum = a + b + cin, carry-out in sum[N].
module brent_add_arbiter_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N:0]   sum
);

    // Down-sweep starts one level below the root of the up-sweep tree.
    localparam int TOP = (1 << $clog2(N)) / 4;

    logic [N-1:0] p_bit;
    logic [N-1:0] gg;
    logic [N-1:0] pp;

    always_comb begin
        p_bit = a ^ b;
        gg    = a & b;
        pp    = p_bit;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = TOP; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        sum = {gg[N-1], p_bit ^ {gg[N-2:0], cin}};
    end

endmodule

// File: rtl/brent_add_arbiter.sv
// Round-robin front end sharing one Brent adder among NREQ requesters.
//   state | meaning
//   IDLE  | scanning requests from rr_ptr, grant latches operands
//   CALC  | operand regs drive adder, result captured at end of cycle
//   HOLD  | result offered until consumer accepts it
module brent_add_arbiter
    import brent_pkg::*;
#(
    parameter int N    = BRENT_N,
    parameter int NREQ = BRENT_NREQ,
    parameter int IDW  = BRENT_IDW
) (
    input logic                clk,
    input logic                rst,
    brent_add_arbiter_if.slave bus
);

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           op_cin;
    logic [IDW-1:0] op_id;
    logic [N:0]     add_sum;

    brent_add_arbiter_adder #(.N(N)) u_adder (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .sum (add_sum)
    );

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        bus.req_ready = '0;
        unique case (state)
            IDLE: begin
                if (gnt_any) begin
                    bus.req_ready = NREQ'(1'b1) << gnt_idx;
                    next_state    = CALC;
                end
            end
            CALC: next_state = HOLD;
            HOLD: begin
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_cin        <= 1'b0;
            op_id         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_id    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a   <= bus.req_a[gnt_idx*N +: N];
                        op_b   <= bus.req_b[gnt_idx*N +: N];
                        op_cin <= bus.req_cin[gnt_idx];
                        op_id  <= gnt_idx;
                    end
                end
                CALC: begin
                    bus.rsp_sum   <= add_sum;
                    bus.rsp_id    <= op_id;
                    bus.rsp_valid <= 1'b1;
                end
                HOLD: begin
                    // Pointer only advances once the result is consumed.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        rr_ptr        <= IDW'(next_idx(int'(op_id), NREQ));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_brent_add_arbiter.sv
// Self-checking bench: cycle-level protocol model plus directed and random stimulus.
module tb_brent_add_arbiter;
    import brent_pkg::*;

    localparam int N    = BRENT_N;
    localparam int NREQ = BRENT_NREQ;
    localparam int IDW  = BRENT_IDW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    brent_add_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    brent_add_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;

    logic [N-1:0] ra [NREQ];
    logic [N-1:0] rb [NREQ];
    logic         rc [NREQ];
    logic         rv [NREQ];
    logic [NREQ-1:0] hs_last = '0;
    bit rand_en = 1'b0;
    bit auto_renew = 1'b0;
    bit chk_en = 1'b0;

    // model: a request granted while free is answered two cycles later and
    // blocks the bus until consumed; scan starts after the last served id
    int         m_ptr = 0;
    bit         m_busy = 1'b0;
    bit         m_rv = 1'b0;
    logic [N:0] m_sum = '0;
    int         m_id = 0;
    logic [NREQ-1:0] exp_rdy;
    int         g;
    int grant_id_q[$];
    int grant_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]     = rv[i];
            bus.req_a[i*N +: N]  = ra[i];
            bus.req_b[i*N +: N]  = rb[i];
            bus.req_cin[i]       = rc[i];
        end
    endtask

    task automatic new_op(input int i);
        int sel;
        sel = $urandom_range(7, 0);
        ra[i] = (sel == 0) ? 32'hFFFF_FFFF : $urandom;
        rb[i] = (sel <= 1) ? 32'hFFFF_FFFF : $urandom;
        rc[i] = $urandom_range(1, 0) == 1;
        rv[i] = 1'b1;
    endtask

    task automatic post(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        ra[i] = a;
        rb[i] = b;
        rc[i] = c;
        rv[i] = 1'b1;
        pack();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_en = 1'b0;
        auto_renew = 1'b0;
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
        pack();
        wait_cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        at_neg();
        while (!bus.rsp_valid && n < 20) begin
            at_neg();
            n++;
        end
        if (!bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: no rsp_valid within 20 cycles", name);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        exp_rdy = '0;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        hs_last = bus.req_valid & bus.req_ready;
        if (chk_en) begin
            check("req_ready", bus.req_ready, exp_rdy);
            check("rsp_valid", bus.rsp_valid, m_rv);
            if (m_rv) begin
                check("rsp_sum", bus.rsp_sum, m_sum);
                check("rsp_id", bus.rsp_id, m_id);
            end
            if (rst) begin
                m_ptr = 0; m_busy = 1'b0; m_rv = 1'b0; m_sum = '0; m_id = 0;
            end else if (m_rv) begin
                if (bus.rsp_ready) begin
                    m_rv = 1'b0;
                    m_busy = 1'b0;
                    m_ptr = (m_id + 1) % NREQ;
                end
            end else if (m_busy) begin
                m_rv = 1'b1;
            end else if (g >= 0) begin
                m_busy = 1'b1;
                m_id = g;
                m_sum = {1'b0, ra[g]} + {1'b0, rb[g]} + {{N{1'b0}}, rc[g]};
                grant_id_q.push_back(g);
                grant_cyc_q.push_back(cyc);
                hs_count++;
            end
        end
        cyc++;
    end

    // requester/consumer driver
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_last[i]) begin
                if (auto_renew || (rand_en && $urandom_range(1, 0) == 1)) new_op(i);
                else rv[i] = 1'b0;
            end else if (rand_en) begin
                if (!rv[i] && $urandom_range(2, 0) == 0) new_op(i);
                else if (rv[i] && $urandom_range(15, 0) == 0) rv[i] = 1'b0;
            end
        end
        if (rand_en) bus.rsp_ready = ($urandom_range(3, 0) != 0);
        pack();
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_rr[5];
        exp_rr = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = 1'b0;
        end
        bus.rsp_ready = 1'b0;
        pack();

        // reset
        repeat (2) @(posedge clk);
        at_neg();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_sum", bus.rsp_sum, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        chk_en = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        repeat (3) begin
            at_neg();
            check("idle_no_valid_ready", bus.req_ready, 0);
        end

        // single request
        wait_cyc(1);
        bus.rsp_ready = 1'b1;
        post(2, 32'd5, 32'd7, 1'b1);
        at_neg();
        check("single_grant", bus.req_ready, 4'b0100);
        at_neg();
        check("single_calc_valid", bus.rsp_valid, 0);
        at_neg();
        check("single_valid", bus.rsp_valid, 1);
        check("single_sum", bus.rsp_sum, 33'd13);
        check("single_id", bus.rsp_id, 2);
        at_neg();
        check("single_consumed", bus.rsp_valid, 0);

        // carry-out
        wait_cyc(1);
        post(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_rsp("carry1_wait");
        check("carry1_sum", bus.rsp_sum, 33'h1_FFFF_FFFF);
        wait_cyc(2);
        post(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_rsp("carry2_wait");
        check("carry2_sum", bus.rsp_sum, 33'h1_0000_0000);

        // round-robin with everyone requesting
        wait_cyc(1);
        do_reset();
        grant_id_q.delete();
        grant_cyc_q.delete();
        bus.rsp_ready = 1'b1;
        auto_renew = 1'b1;
        for (int i = 0; i < NREQ; i++) post(i, 32'(i * 100), 32'(i + 1), 1'b0);
        wait_cyc(16);
        auto_renew = 1'b0;
        if (grant_id_q.size() < 5) begin
            checks++;
            errors++;
            $display("FAIL rr_count: got %0d grants expected at least 5", grant_id_q.size());
        end else begin
            for (int j = 0; j < 5; j++) check("rr_order", grant_id_q[j], exp_rr[j]);
            for (int j = 1; j < 5; j++) check("rr_spacing", grant_cyc_q[j] - grant_cyc_q[j-1], 3);
        end

        // backpressure
        do_reset();
        bus.rsp_ready = 1'b0;
        post(1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        wait_rsp("bp_wait");
        wait_cyc(1);
        post(0, 32'd1, 32'd2, 1'b0);
        repeat (10) begin
            at_neg();
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_sum", bus.rsp_sum, 33'h0_2222_2222);
            check("bp_id", bus.rsp_id, 1);
            check("bp_ready", bus.req_ready, 0);
        end
        wait_cyc(1);
        bus.rsp_ready = 1'b1;
        at_neg();
        check("bp_last_valid", bus.rsp_valid, 1);
        at_neg();
        check("bp_released_valid", bus.rsp_valid, 0);
        check("bp_next_grant", bus.req_ready, 4'b0001);
        wait_cyc(4);

        // reset during CALC
        do_reset();
        bus.rsp_ready = 1'b1;
        post(3, 32'd9, 32'd10, 1'b0);
        at_neg();
        check("midrst_grant", bus.req_ready, 4'b1000);
        wait_cyc(1);
        rst = 1'b1;
        at_neg();
        check("midrst_calc_valid", bus.rsp_valid, 0);
        wait_cyc(1);
        rst = 1'b0;
        post(1, 32'd3, 32'd4, 1'b0);
        post(3, 32'd20, 32'd22, 1'b1);
        at_neg();
        check("midrst_no_rsp", bus.rsp_valid, 0);
        check("midrst_lowest_grant", bus.req_ready, 4'b0010);
        wait_rsp("midrst_wait");
        check("midrst_id", bus.rsp_id, 1);
        check("midrst_sum", bus.rsp_sum, 33'd7);

        // random traffic with random stalls
        wait_cyc(1);
        do_reset();
        hs_count = 0;
        rand_en = 1'b1;
        wait_cyc(3000);
        rand_en = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_cyc(30);
        checks++;
        if (hs_count < 200) begin
            errors++;
            $display("FAIL random_activity: got %0d handshakes expected at least 200", hs_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
